axi_lite_bus_arbiter: RTL and testbench
=======================================

Name: axi_lite_bus_arbiter

Overview:
- Shares the single AXI4-Lite peripheral bus-side start/busy interface (write_*/read_*) between two requesters: m0 is the core MEM stage, m1 is a secondary master (debug loader/DMA).
- Sits between the requesters and axi4_lite_peripheral_top.
- Serializes transactions one at a time, holds one pending request per channel per requester, arbitrates round-robin or fixed-priority, and routes completion and read data back to the owner.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
FIXED_PRIO, 0, 0 = round-robin; 1 = m0 always wins ties

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
mN_write_start  in  1  per requester N in {0,1}; single-cycle write request pulse
mN_write_addr  in  ADDR_WIDTH  write address, sampled with start
mN_write_data  in  DATA_WIDTH  write data, sampled with start
mN_write_strobe  in  DATA_WIDTH/8  byte strobes, sampled with start
mN_write_busy  out  1  write accepted and not yet complete
mN_read_start  in  1  single-cycle read request pulse
mN_read_addr  in  ADDR_WIDTH  read address, sampled with start
mN_read_data  out  DATA_WIDTH  last completed read data, held
mN_read_busy  out  1  read accepted and not yet complete
s_write_start  out  1  downstream write start
s_write_addr, s_write_data, s_write_strobe  out  ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  downstream write payload
s_write_busy  in  1  downstream write in progress
s_read_start  out  1  downstream read start
s_read_addr  out  ADDR_WIDTH  downstream read address
s_read_data  in  DATA_WIDTH  downstream read data
s_read_busy  in  1  downstream read in progress
grant  out  1  owner of current/last transaction (0 = m0, 1 = m1)
bus_active  out  1  high in any state other than IDLE
protocol_err  out  1  sticky; set when a start arrives while that channel is already busy

Behaviour:
- Reset values: all outputs 0; pending slots empty; state IDLE; last_grant = 1, so m0 wins the first round-robin tie.
- Capture: mN_X_start with the slot empty latches the payload into the slot at the clock edge.
- mN_X_busy is combinational: start OR slot pending OR in-flight. It is high in the start cycle.
- A start while the same channel is busy is ignored and sets protocol_err. Only rst clears protocol_err.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if any slot is pending, select a requester and register grant/op/payload, then go to ISSUE.
  - Requester selection: round-robin picks the requester other than last_grant when both are pending. FIXED_PRIO=1 picks m0.
  - Within the chosen requester, write before read.
  - ISSUE: drive s_write_start or s_read_start high for exactly one cycle with the registered payload, then go to WAIT.
  - WAIT: downstream guarantees busy is high the cycle after start. When the matching s_X_busy is sampled low, go to RESP.
  - WAIT read completion: on that same edge, capture s_read_data into mgrant_read_data.
  - RESP: clear the owner's slot at the edge leaving RESP, update last_grant, then go to IDLE.
  - The owner's busy is low from the first cycle in IDLE.
- Latency with no contention: start at cycle t; IDLE at t+1; ISSUE at t+2; WAIT from t+3. If the slave completes (busy low) at cycle d, busy drops at d+2. Read data is valid and stable when busy first reads low.
- A start arriving at the owner during RESP is still busy and is treated as an error.
- The other requester may capture into its slot at any time; it is serviced in the next IDLE.
- mN_read_data of the non-owner never changes.
- s_* payload outputs hold their value outside ISSUE. Only start is pulsed.
- Reset mid-transaction: rst returns to the reset state at the next edge and drops pending slots. The downstream slave shares rst.
- Downstream read and write are never concurrent.

Decomposition:
- Shared package axi_lite_arb_pkg holds:
  - state encoding constants (IDLE=2'd0, ISSUE=1, WAIT=2, RESP=3);
  - OP_WRITE/OP_READ;
  - requester ID constants.
- One natural sub-module: axi_lite_req_slot, instantiated four times. It holds the pending flag, payload registers, error detection, and the busy term for one requester channel.

Test Plan:
- Single m0 write to addr 0x0000_0010, data 0xA5A5_A5A5, strobe 0xF.
  Required: s_write_start pulses at t+2 with the same payload; m0_write_busy is high from t and falls two cycles after s_write_busy falls; grant=0.
- m1 read of 0x0000_0020, slave returns 0x1234_5678.
  Required: m1_read_data=0x1234_5678 when m1_read_busy falls; m0_read_data remains 0.
- m0 write and m1 read started in the same cycle, round-robin.
  Required: m0 is serviced first, then m1. Repeat both: m1 first, then m0 (alternation).
- FIXED_PRIO=1 with both requesters continuously restarting.
  Required: m0 is always granted whenever pending; m1 is granted only when m0's slots are empty.
- m0 pulses write_start and read_start together.
  Required: the downstream write completes before s_read_start; both busies are high from the start cycle.
- Second m0_write_start while m0_write_busy is high.
  Required: protocol_err=1 and the payload is ignored. Then rst held for one cycle mid-WAIT: all busies=0, bus_active=0, protocol_err=0 the next cycle.

Source files
------------

// File: rtl/axi_lite_arb_pkg.sv
// rtl/axi_lite_arb_pkg.sv - shared state, op and requester encodings for the bus arbiter
package axi_lite_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_READ  = 1'b1;

    localparam logic REQ_M0 = 1'b0;
    localparam logic REQ_M1 = 1'b1;

endpackage

// File: rtl/axi_lite_req_slot.sv
// rtl/axi_lite_req_slot.sv - one pending request slot for a single requester channel
module axi_lite_req_slot #(
    parameter int PAYLOAD_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [PAYLOAD_WIDTH-1:0] payload,
    input  logic                     clear,
    output logic                     pending,
    output logic [PAYLOAD_WIDTH-1:0] slot_payload,
    output logic                     busy,
    output logic                     err
);

    // Latch a start into an empty slot; the slot stays pending until its transaction retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending      <= 1'b0;
            slot_payload <= '0;
        end else if (clear) begin
            pending <= 1'b0;
        end else if (start && !pending) begin
            pending      <= 1'b1;
            slot_payload <= payload;
        end
    end

    // A pending slot covers both the queued and the in-flight phase of the request.
    assign busy = start | pending;
    assign err  = start & pending;

endmodule

// File: rtl/axi_lite_bus_arbiter.sv
// rtl/axi_lite_bus_arbiter.sv - two-requester arbiter in front of a single AXI4-Lite start/busy port
module axi_lite_bus_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    m0_write_start,
    input  logic [ADDR_WIDTH-1:0]   m0_write_addr,
    input  logic [DATA_WIDTH-1:0]   m0_write_data,
    input  logic [DATA_WIDTH/8-1:0] m0_write_strobe,
    output logic                    m0_write_busy,
    input  logic                    m0_read_start,
    input  logic [ADDR_WIDTH-1:0]   m0_read_addr,
    output logic [DATA_WIDTH-1:0]   m0_read_data,
    output logic                    m0_read_busy,
    input  logic                    m1_write_start,
    input  logic [ADDR_WIDTH-1:0]   m1_write_addr,
    input  logic [DATA_WIDTH-1:0]   m1_write_data,
    input  logic [DATA_WIDTH/8-1:0] m1_write_strobe,
    output logic                    m1_write_busy,
    input  logic                    m1_read_start,
    input  logic [ADDR_WIDTH-1:0]   m1_read_addr,
    output logic [DATA_WIDTH-1:0]   m1_read_data,
    output logic                    m1_read_busy,
    output logic                    s_write_start,
    output logic [ADDR_WIDTH-1:0]   s_write_addr,
    output logic [DATA_WIDTH-1:0]   s_write_data,
    output logic [DATA_WIDTH/8-1:0] s_write_strobe,
    input  logic                    s_write_busy,
    output logic                    s_read_start,
    output logic [ADDR_WIDTH-1:0]   s_read_addr,
    input  logic [DATA_WIDTH-1:0]   s_read_data,
    input  logic                    s_read_busy,
    output logic                    grant,
    output logic                    bus_active,
    output logic                    protocol_err
);
    import axi_lite_arb_pkg::*;

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int WR_WIDTH   = ADDR_WIDTH + DATA_WIDTH + STRB_WIDTH;

    arb_state_t          state, next_state;
    logic                op;
    logic                last_grant;
    logic [1:0]          wr_pending, rd_pending, wr_err, rd_err, wr_clear, rd_clear;
    logic [WR_WIDTH-1:0] wr_payload [2];
    logic [ADDR_WIDTH-1:0] rd_payload [2];
    logic                p0, p1, any_pending, sel_req, sel_write, wait_done;

    axi_lite_req_slot #(.PAYLOAD_WIDTH(WR_WIDTH)) u_m0_wr (
        .clk(clk), .rst(rst), .start(m0_write_start),
        .payload({m0_write_addr, m0_write_data, m0_write_strobe}),
        .clear(wr_clear[0]), .pending(wr_pending[0]), .slot_payload(wr_payload[0]),
        .busy(m0_write_busy), .err(wr_err[0])
    );

    axi_lite_req_slot #(.PAYLOAD_WIDTH(ADDR_WIDTH)) u_m0_rd (
        .clk(clk), .rst(rst), .start(m0_read_start), .payload(m0_read_addr),
        .clear(rd_clear[0]), .pending(rd_pending[0]), .slot_payload(rd_payload[0]),
        .busy(m0_read_busy), .err(rd_err[0])
    );

    axi_lite_req_slot #(.PAYLOAD_WIDTH(WR_WIDTH)) u_m1_wr (
        .clk(clk), .rst(rst), .start(m1_write_start),
        .payload({m1_write_addr, m1_write_data, m1_write_strobe}),
        .clear(wr_clear[1]), .pending(wr_pending[1]), .slot_payload(wr_payload[1]),
        .busy(m1_write_busy), .err(wr_err[1])
    );

    axi_lite_req_slot #(.PAYLOAD_WIDTH(ADDR_WIDTH)) u_m1_rd (
        .clk(clk), .rst(rst), .start(m1_read_start), .payload(m1_read_addr),
        .clear(rd_clear[1]), .pending(rd_pending[1]), .slot_payload(rd_payload[1]),
        .busy(m1_read_busy), .err(rd_err[1])
    );

    // Only the owner's channel retires, on the cycle leaving RESP.
    assign wr_clear[0] = (state == RESP) && (grant == REQ_M0) && (op == OP_WRITE);
    assign rd_clear[0] = (state == RESP) && (grant == REQ_M0) && (op == OP_READ);
    assign wr_clear[1] = (state == RESP) && (grant == REQ_M1) && (op == OP_WRITE);
    assign rd_clear[1] = (state == RESP) && (grant == REQ_M1) && (op == OP_READ);

    // Requester selection: ties go to m0 under fixed priority, else to whoever did not go last.
    always_comb begin
        p0          = wr_pending[0] | rd_pending[0];
        p1          = wr_pending[1] | rd_pending[1];
        any_pending = p0 | p1;
        if (p0 && p1) begin
            sel_req = (FIXED_PRIO != 0) ? REQ_M0 : ~last_grant;
        end else begin
            sel_req = p0 ? REQ_M0 : REQ_M1;
        end
        sel_write = wr_pending[sel_req];
    end

    assign wait_done  = (state == WAIT) && ((op == OP_WRITE) ? !s_write_busy : !s_read_busy);
    assign bus_active = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and the one-cycle downstream start pulse.
    always_comb begin
        next_state    = state;
        s_write_start = 1'b0;
        s_read_start  = 1'b0;
        case (state)
            IDLE:  if (any_pending) next_state = ISSUE;
            ISSUE: begin
                s_write_start = (op == OP_WRITE);
                s_read_start  = (op == OP_READ);
                next_state    = WAIT;
            end
            WAIT:  if (wait_done) next_state = RESP;
            RESP:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Grant/op/payload registration, read-data return and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant          <= REQ_M0;
            op             <= OP_WRITE;
            last_grant     <= REQ_M1;
            s_write_addr   <= '0;
            s_write_data   <= '0;
            s_write_strobe <= '0;
            s_read_addr    <= '0;
            m0_read_data   <= '0;
            m1_read_data   <= '0;
            protocol_err   <= 1'b0;
        end else begin
            protocol_err <= protocol_err | (|wr_err) | (|rd_err);
            if (state == IDLE && any_pending) begin
                grant <= sel_req;
                op    <= sel_write ? OP_WRITE : OP_READ;
                if (sel_write) begin
                    {s_write_addr, s_write_data, s_write_strobe} <= wr_payload[sel_req];
                end else begin
                    s_read_addr <= rd_payload[sel_req];
                end
            end
            if (wait_done && op == OP_READ) begin
                if (grant == REQ_M1) begin
                    m1_read_data <= s_read_data;
                end else begin
                    m0_read_data <= s_read_data;
                end
            end
            if (state == RESP) begin
                last_grant <= grant;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_bus_arbiter.sv
// tb/tb_axi_lite_bus_arbiter.sv - self-checking bench for axi_lite_bus_arbiter (round-robin and fixed-priority)
module tb_axi_lite_bus_arbiter;

    localparam int LAT = 3;
    localparam logic [31:0] RD_KEY = 32'h1234_5658;

    localparam int S_WS = 0, S_WA = 1, S_M0WB = 2, S_GR0 = 3, S_M1RD = 4, S_M0RD = 5,
                   S_PERR = 6, S_ACT = 7, S_M1RB = 8, S_RS = 9, S_GR1 = 10, S_WD = 11, S_M0RB = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        st [2][2];
    logic [31:0] waddr [2];
    logic [31:0] wdata [2];
    logic [3:0]  wstrb [2];
    logic [31:0] raddr [2];

    logic        busy_o [2][2][2];
    logic [31:0] rdata_o [2][2];
    logic        s_ws [2], s_rs [2], s_wb [2], s_rb [2], grant_o [2], act_o [2], perr_o [2];
    logic [31:0] s_wa [2], s_wd [2], s_ra [2], s_rd [2];
    logic [3:0]  s_wst [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        int          wcnt;
        int          rcnt;
        logic [31:0] ra_l;

        axi_lite_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIO(g)) u_dut (
            .clk(clk), .rst(rst),
            .m0_write_start(st[0][0]), .m0_write_addr(waddr[0]), .m0_write_data(wdata[0]),
            .m0_write_strobe(wstrb[0]), .m0_write_busy(busy_o[g][0][0]),
            .m0_read_start(st[0][1]), .m0_read_addr(raddr[0]), .m0_read_data(rdata_o[g][0]),
            .m0_read_busy(busy_o[g][0][1]),
            .m1_write_start(st[1][0]), .m1_write_addr(waddr[1]), .m1_write_data(wdata[1]),
            .m1_write_strobe(wstrb[1]), .m1_write_busy(busy_o[g][1][0]),
            .m1_read_start(st[1][1]), .m1_read_addr(raddr[1]), .m1_read_data(rdata_o[g][1]),
            .m1_read_busy(busy_o[g][1][1]),
            .s_write_start(s_ws[g]), .s_write_addr(s_wa[g]), .s_write_data(s_wd[g]),
            .s_write_strobe(s_wst[g]), .s_write_busy(s_wb[g]),
            .s_read_start(s_rs[g]), .s_read_addr(s_ra[g]), .s_read_data(s_rd[g]),
            .s_read_busy(s_rb[g]),
            .grant(grant_o[g]), .bus_active(act_o[g]), .protocol_err(perr_o[g])
        );

        // Slave stand-in: busy for LAT cycles starting the cycle after start.
        always @(posedge clk) begin
            if (rst) begin
                wcnt <= 0;
                rcnt <= 0;
                ra_l <= '0;
            end else begin
                if (s_ws[g]) wcnt <= LAT;
                else if (wcnt != 0) wcnt <= wcnt - 1;
                if (s_rs[g]) begin
                    rcnt <= LAT;
                    ra_l <= s_ra[g];
                end else if (rcnt != 0) begin
                    rcnt <= rcnt - 1;
                end
            end
        end
        assign s_wb[g] = (wcnt != 0);
        assign s_rb[g] = (rcnt != 0);
        assign s_rd[g] = ra_l ^ RD_KEY;
    end

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
        string       name;
    } pin_t;
    pin_t pins [$];

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    bit          m_pend [2][2][2];
    logic [31:0] m_wa [2][2], m_wd [2][2], m_ra [2][2];
    logic [3:0]  m_ws [2][2];
    bit          m_act [2];
    int          m_tdec [2], m_own [2], m_op [2], m_last [2];
    logic        m_grant [2], m_err [2];
    logic [31:0] m_rd [2][2];
    logic [31:0] m_swa [2], m_swd [2], m_sra [2];
    logic [3:0]  m_sws [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pin_val(int s);
        case (s)
            S_WS:   return 32'(s_ws[0]);
            S_WA:   return s_wa[0];
            S_M0WB: return 32'(busy_o[0][0][0]);
            S_GR0:  return 32'(grant_o[0]);
            S_M1RD: return rdata_o[0][1];
            S_M0RD: return rdata_o[0][0];
            S_PERR: return 32'(perr_o[0]);
            S_ACT:  return 32'(act_o[0]);
            S_M1RB: return 32'(busy_o[0][1][1]);
            S_RS:   return 32'(s_rs[0]);
            S_GR1:  return 32'(grant_o[1]);
            S_WD:   return s_wd[0];
            S_M0RB: return 32'(busy_o[0][0][1]);
            default: return 32'hDEAD_DEAD;
        endcase
    endfunction

    // Transaction-timing model: each transaction occupies the bus for LAT+4 cycles from its decision cycle.
    always @(negedge clk) begin
        int   n, own, op;
        bit   p0, p1;
        logic exp_ws, exp_rs, exp_act;
        n = cyc;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                for (int r = 0; r < 2; r++) begin
                    for (int c = 0; c < 2; c++) m_pend[i][r][c] = 1'b0;
                    m_rd[i][r] = '0;
                end
                m_act[i] = 1'b0; m_tdec[i] = 0; m_own[i] = 0; m_op[i] = 0; m_last[i] = 1;
                m_grant[i] = 1'b0; m_err[i] = 1'b0;
                m_swa[i] = '0; m_swd[i] = '0; m_sws[i] = '0; m_sra[i] = '0;
            end else begin
                if (m_act[i] && n == m_tdec[i] + LAT + 4) begin
                    m_pend[i][m_own[i]][m_op[i]] = 1'b0;
                    m_last[i] = m_own[i];
                    m_act[i] = 1'b0;
                end
                if (!m_act[i]) begin
                    p0 = m_pend[i][0][0] | m_pend[i][0][1];
                    p1 = m_pend[i][1][0] | m_pend[i][1][1];
                    if (p0 || p1) begin
                        if (p0 && p1) own = (i == 1) ? 0 : 1 - m_last[i];
                        else own = p0 ? 0 : 1;
                        op = m_pend[i][own][0] ? 0 : 1;
                        m_act[i] = 1'b1; m_tdec[i] = n; m_own[i] = own; m_op[i] = op;
                    end
                end
                if (m_act[i] && n == m_tdec[i] + 1) begin
                    m_grant[i] = m_own[i][0];
                    if (m_op[i] == 0) begin
                        m_swa[i] = m_wa[i][m_own[i]];
                        m_swd[i] = m_wd[i][m_own[i]];
                        m_sws[i] = m_ws[i][m_own[i]];
                    end else begin
                        m_sra[i] = m_ra[i][m_own[i]];
                    end
                end
                if (m_act[i] && m_op[i] == 1 && n == m_tdec[i] + LAT + 3)
                    m_rd[i][m_own[i]] = m_sra[i] ^ RD_KEY;
                exp_ws  = m_act[i] && n == m_tdec[i] + 1 && m_op[i] == 0;
                exp_rs  = m_act[i] && n == m_tdec[i] + 1 && m_op[i] == 1;
                exp_act = m_act[i] && n > m_tdec[i];

                for (int r = 0; r < 2; r++) begin
                    for (int c = 0; c < 2; c++)
                        chk($sformatf("i%0d m%0d_%s_busy", i, r, c ? "read" : "write"),
                            32'(busy_o[i][r][c]), 32'(st[r][c] | m_pend[i][r][c]));
                    chk($sformatf("i%0d m%0d_read_data", i, r), rdata_o[i][r], m_rd[i][r]);
                end
                chk($sformatf("i%0d s_write_start", i), 32'(s_ws[i]), 32'(exp_ws));
                chk($sformatf("i%0d s_read_start", i), 32'(s_rs[i]), 32'(exp_rs));
                chk($sformatf("i%0d s_write_addr", i), s_wa[i], m_swa[i]);
                chk($sformatf("i%0d s_write_data", i), s_wd[i], m_swd[i]);
                chk($sformatf("i%0d s_write_strobe", i), 32'(s_wst[i]), 32'(m_sws[i]));
                chk($sformatf("i%0d s_read_addr", i), s_ra[i], m_sra[i]);
                chk($sformatf("i%0d grant", i), 32'(grant_o[i]), 32'(m_grant[i]));
                chk($sformatf("i%0d bus_active", i), 32'(act_o[i]), 32'(exp_act));
                chk($sformatf("i%0d protocol_err", i), 32'(perr_o[i]), 32'(m_err[i]));

                for (int r = 0; r < 2; r++) begin
                    for (int c = 0; c < 2; c++) begin
                        if (st[r][c]) begin
                            if (m_pend[i][r][c]) begin
                                m_err[i] = 1'b1;
                            end else begin
                                m_pend[i][r][c] = 1'b1;
                                if (c == 0) begin
                                    m_wa[i][r] = waddr[r]; m_wd[i][r] = wdata[r]; m_ws[i][r] = wstrb[r];
                                end else begin
                                    m_ra[i][r] = raddr[r];
                                end
                            end
                        end
                    end
                end
            end
        end
        if (!rst) begin
            while (pins.size() > 0 && pins[0].cyc <= n) begin
                chk({"pin ", pins[0].name}, pin_val(pins[0].sig), pins[0].val);
                void'(pins.pop_front());
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pin(input int dc, input int sig, input logic [31:0] val, input string name);
        pin_t p;
        p.cyc = cyc + dc; p.sig = sig; p.val = val; p.name = name;
        pins.push_back(p);
    endtask

    task automatic pulse(input bit w0, input bit r0, input bit w1, input bit r1);
        st[0][0] = w0; st[0][1] = r0; st[1][0] = w1; st[1][1] = r1;
        tick();
        st[0][0] = 1'b0; st[0][1] = 1'b0; st[1][0] = 1'b0; st[1][1] = 1'b0;
    endtask

    initial begin
        for (int r = 0; r < 2; r++) begin
            st[r][0] = 1'b0; st[r][1] = 1'b0;
            waddr[r] = '0; wdata[r] = '0; wstrb[r] = '0; raddr[r] = '0;
        end
        repeat (3) tick();
        rst = 1'b0;

        pin(0, S_PERR, 0, "reset protocol_err");
        pin(0, S_ACT, 0, "reset bus_active");
        pin(0, S_M0RD, 0, "reset m0_read_data");
        tick();

        waddr[0] = 32'h0000_0010; wdata[0] = 32'hA5A5_A5A5; wstrb[0] = 4'hF;
        pin(0, S_M0WB, 1, "wr busy in start cycle");
        pin(2, S_WS, 1, "wr s_write_start at t+2");
        pin(2, S_WA, 32'h10, "wr s_write_addr");
        pin(2, S_WD, 32'hA5A5_A5A5, "wr s_write_data");
        pin(2, S_GR0, 0, "wr grant m0");
        pin(7, S_M0WB, 1, "wr busy one cycle before drop");
        pin(8, S_M0WB, 0, "wr busy drops slave-done+2");
        pulse(1, 0, 0, 0);
        repeat (12) tick();

        raddr[1] = 32'h0000_0020;
        pin(2, S_RS, 1, "rd s_read_start at t+2");
        pin(7, S_M1RB, 1, "rd busy before drop");
        pin(8, S_M1RB, 0, "rd busy drop");
        pin(8, S_M1RD, 32'h1234_5678, "rd m1_read_data");
        pin(8, S_M0RD, 0, "rd m0_read_data untouched");
        pulse(0, 0, 0, 1);
        repeat (12) tick();

        waddr[0] = 32'h0000_0030; wdata[0] = 32'h1111_2222; raddr[1] = 32'h0000_0040;
        pin(2, S_WS, 1, "tie1 m0 write first");
        pin(2, S_GR0, 0, "tie1 grant m0");
        pin(9, S_RS, 1, "tie1 m1 read second");
        pin(9, S_GR0, 1, "tie1 grant m1");
        pulse(1, 0, 0, 1);
        repeat (20) tick();

        waddr[0] = 32'h0000_0050; wdata[0] = 32'h3333_4444;
        pulse(1, 0, 0, 0);
        repeat (12) tick();
        waddr[0] = 32'h0000_0060; wdata[0] = 32'h5555_6666; raddr[1] = 32'h0000_0070;
        pin(2, S_RS, 1, "tie2 m1 read first");
        pin(2, S_GR0, 1, "tie2 rr grant m1");
        pin(2, S_GR1, 0, "tie2 fixed grant m0");
        pin(9, S_WS, 1, "tie2 m0 write second");
        pin(9, S_GR0, 0, "tie2 rr grant m0");
        pulse(1, 0, 0, 1);
        repeat (20) tick();

        waddr[0] = 32'h0000_0080; wdata[0] = 32'hDEAD_BEEF; wstrb[0] = 4'h3; raddr[0] = 32'h0000_0090;
        pin(0, S_M0WB, 1, "wr+rd write busy at start");
        pin(0, S_M0RB, 1, "wr+rd read busy at start");
        pin(2, S_WS, 1, "wr+rd write issued first");
        pin(2, S_RS, 0, "wr+rd no read with write");
        pin(9, S_RS, 1, "wr+rd read after write");
        pin(9, S_M0WB, 0, "wr+rd write done");
        pin(9, S_M0RB, 1, "wr+rd read still busy");
        pulse(1, 1, 0, 0);
        repeat (20) tick();

        waddr[0] = 32'h0000_00A0; wdata[0] = 32'h0BAD_0001; wstrb[0] = 4'hF;
        pin(0, S_PERR, 0, "err clear before");
        pin(1, S_M0WB, 1, "err second start while busy");
        pin(2, S_PERR, 1, "err protocol_err set");
        pin(2, S_WA, 32'hA0, "err payload ignored addr");
        pin(2, S_WD, 32'h0BAD_0001, "err payload ignored data");
        pin(5, S_ACT, 0, "rst bus_active");
        pin(5, S_PERR, 0, "rst protocol_err");
        pin(5, S_M0WB, 0, "rst m0_write_busy");
        pulse(1, 0, 0, 0);
        waddr[0] = 32'h0000_00B0; wdata[0] = 32'h0BAD_0002;
        pulse(1, 0, 0, 0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();

        for (int k = 0; k < 60; k++) begin
            waddr[0] = 32'h100 + 32'(k) * 4; wdata[0] = 32'hC000_0000 + 32'(k);
            raddr[1] = 32'h200 + 32'(k) * 4;
            st[0][0] = (k % 5 == 0);
            st[1][1] = (k % 3 == 0);
            tick();
        end
        st[0][0] = 1'b0; st[1][1] = 1'b0;
        repeat (35) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
